// File: rtl/wb_stage.sv
// MIPS32 write-back stage: owns the 32x32 register file, commits RR/RM/LOAD results,
// and tracks the sticky HALTED flag and retired count. Same-cycle write-through bypass under `WB_BYPASS_EN.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       type_i,
  input  logic [31:0]      ir_i,
  input  logic [31:0]      aluout_i,
  input  logic [31:0]      lmd_i,
  input  logic             taken_branch_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  output logic [31:0]      rs_data_o,
  output logic [31:0]      rt_data_o,
  output logic             wb_en_o,
  output logic [4:0]       wb_addr_o,
  output logic [31:0]      wb_data_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [2:0] T_RR     = 3'b000;
  localparam logic [2:0] T_RM     = 3'b001;
  localparam logic [2:0] T_LOAD   = 3'b010;
  localparam logic [2:0] T_HALT   = 3'b101;

  logic [31:0]      rf_q [32];
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             live;
  logic [4:0]       dest;
  logic [31:0]      value;
  logic             wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] r;
    r = (addr == 5'd0) ? 32'd0 : rf_q[addr];
`ifdef WB_BYPASS_EN
    if (wr_en && (addr == dest)) r = value;
`endif
    return r;
  endfunction

  always_comb begin
    live  = !halted_q && !taken_branch_i && (type_i <= T_HALT);
    dest  = (type_i == T_RR) ? ir_i[15:11] : ir_i[20:16];
    value = (type_i == T_LOAD) ? lmd_i : aluout_i;
    wr_en = live && (type_i == T_RR || type_i == T_RM || type_i == T_LOAD) && (dest != 5'd0);
  end

  always_comb begin
    halted_d  = halted_q;
    retired_d = retired_q;
    if (live) begin
      retired_d = sat_inc(retired_q);
      if (type_i == T_HALT) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // Register file; a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wr_en) begin
      rf_q[dest] <= value;
    end
  end

  assign wb_en_o   = wr_en;
  assign wb_addr_o = wr_en ? dest : 5'd0;
  assign wb_data_o = wr_en ? value : 32'd0;
  assign rs_data_o = read_port(rs_addr_i);
  assign rt_data_o = read_port(rt_addr_i);
  assign halted_o  = halted_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second 3-bit-counter instance exercises retired saturation.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  type_i;
  logic [31:0] ir_i, aluout_i, lmd_i;
  logic        taken_branch_i;
  logic [4:0]  rs_addr_i, rt_addr_i;
  logic [31:0] rs_data_o, rt_data_o, wb_data_o;
  logic        wb_en_o, halted_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] retired_o;

  logic [31:0] s_rs, s_rt, s_wbd;
  logic        s_wbe, s_halt;
  logic [4:0]  s_wba;
  logic [2:0]  s_ret;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .type_i(type_i), .ir_i(ir_i), .aluout_i(aluout_i),
    .lmd_i(lmd_i), .taken_branch_i(taken_branch_i), .rs_addr_i(rs_addr_i),
    .rt_addr_i(rt_addr_i), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .halted_o(halted_o), .retired_o(retired_o)
  );

  wb_stage #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .type_i(type_i), .ir_i(ir_i), .aluout_i(aluout_i),
    .lmd_i(lmd_i), .taken_branch_i(taken_branch_i), .rs_addr_i(rs_addr_i),
    .rt_addr_i(rt_addr_i), .rs_data_o(s_rs), .rt_data_o(s_rt),
    .wb_en_o(s_wbe), .wb_addr_o(s_wba), .wb_data_o(s_wbd),
    .halted_o(s_halt), .retired_o(s_ret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    type_i = 3'b110; ir_i = 32'd0; aluout_i = 32'd0; lmd_i = 32'd0; taken_branch_i = 1'b0;
  endtask

  initial begin
    logic [31:0] coll_exp;
    nop();
    rst = 1'b1; rs_addr_i = 5'd0; rt_addr_i = 5'd0;
    step(); step();
    rst = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs_addr_i = 5'(a); rt_addr_i = 5'(31 - a);
      #1;
      check("reset_rs", rs_data_o, 32'd0);
      check("reset_rt", rt_data_o, 32'd0);
    end
    check("reset_halted", {31'd0, halted_o}, 32'd0);
    check("reset_retired", retired_o, 32'd0);

    // RR to R5
    type_i = 3'b000; ir_i = 32'd5 << 11; aluout_i = 32'h1234_5678;
    #1;
    check("rr_wb_en", {31'd0, wb_en_o}, 32'd1);
    check("rr_wb_addr", {27'd0, wb_addr_o}, 32'd5);
    check("rr_wb_data", wb_data_o, 32'h1234_5678);
    step(); nop(); rs_addr_i = 5'd5; rt_addr_i = 5'd5;
    #1;
    check("rr_r5_rs", rs_data_o, 32'h1234_5678);
    check("rr_r5_rt", rt_data_o, 32'h1234_5678);
    check("rr_retired", retired_o, 32'd1);

    // LOAD to R0
    type_i = 3'b010; ir_i = 32'd0; lmd_i = 32'hDEAD_BEEF;
    #1;
    check("ld0_wb_en", {31'd0, wb_en_o}, 32'd0);
    check("ld0_wb_addr", {27'd0, wb_addr_o}, 32'd0);
    check("ld0_wb_data", wb_data_o, 32'd0);
    step(); nop(); rs_addr_i = 5'd0;
    #1;
    check("ld0_r0", rs_data_o, 32'd0);
    check("ld0_retired", retired_o, 32'd2);

    // Collision: R3=0x11, then write 0x55 while reading R3
    type_i = 3'b000; ir_i = 32'd3 << 11; aluout_i = 32'h11;
    step();
    aluout_i = 32'h55; rs_addr_i = 5'd3; rt_addr_i = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    coll_exp = 32'h55;
`else
    coll_exp = 32'h11;
`endif
    check("coll_rs_same", rs_data_o, coll_exp);
    check("coll_rt_same", rt_data_o, coll_exp);
    step(); nop();
    #1;
    check("coll_rs_next", rs_data_o, 32'h55);
    check("coll_retired", retired_o, 32'd4);

    // LOAD to R8 and RM to R6
    type_i = 3'b010; ir_i = 32'd8 << 16; lmd_i = 32'hCAFE_0001; aluout_i = 32'hFFFF_FFFF;
    step();
    type_i = 3'b001; ir_i = (32'd6 << 16) | (32'd2 << 11); aluout_i = 32'h0000_0A0A;
    #1;
    check("rm_wb_addr", {27'd0, wb_addr_o}, 32'd6);
    step(); nop(); rs_addr_i = 5'd8; rt_addr_i = 5'd6;
    #1;
    check("ld_r8", rs_data_o, 32'hCAFE_0001);
    check("rm_r6", rt_data_o, 32'h0000_0A0A);
    rs_addr_i = 5'd2;
    #1;
    check("rm_r2_untouched", rs_data_o, 32'd0);
    check("ldrm_retired", retired_o, 32'd6);

    // STORE and BRANCH retire without writing
    type_i = 3'b011; ir_i = (32'd10 << 16) | (32'd10 << 11); aluout_i = 32'h77;
    #1;
    check("st_wb_en", {31'd0, wb_en_o}, 32'd0);
    step(); type_i = 3'b100;
    #1;
    check("br_wb_en", {31'd0, wb_en_o}, 32'd0);
    step(); nop(); rs_addr_i = 5'd10;
    #1;
    check("stbr_r10", rs_data_o, 32'd0);
    check("stbr_retired", retired_o, 32'd8);

    // Squashed RM to R7, then squashed HALT
    type_i = 3'b001; ir_i = 32'd7 << 16; aluout_i = 32'hA5; taken_branch_i = 1'b1;
    #1;
    check("sq_wb_en", {31'd0, wb_en_o}, 32'd0);
    step();
    type_i = 3'b101; ir_i = 32'd0;
    step(); nop(); rs_addr_i = 5'd7;
    #1;
    check("sq_r7", rs_data_o, 32'd0);
    check("sq_halted", {31'd0, halted_o}, 32'd0);
    check("sq_retired", retired_o, 32'd8);

    // Live HALT, then ignored RR
    type_i = 3'b101;
    step();
    check("halt_halted", {31'd0, halted_o}, 32'd1);
    check("halt_retired", retired_o, 32'd9);
    type_i = 3'b000; ir_i = 32'd9 << 11; aluout_i = 32'h99; rs_addr_i = 5'd9;
    #1;
    check("halted_wb_en", {31'd0, wb_en_o}, 32'd0);
    step();
    check("halted_r9", rs_data_o, 32'd0);
    check("halted_retired", retired_o, 32'd9);
    check("halted_sticky", {31'd0, halted_o}, 32'd1);

    // Reset mid-halt with RR to R4 presented
    ir_i = 32'd4 << 11; aluout_i = 32'h77; rst = 1'b1;
    step();
    rst = 1'b0; nop(); rs_addr_i = 5'd4; rt_addr_i = 5'd5;
    #1;
    check("rst_halted", {31'd0, halted_o}, 32'd0);
    check("rst_retired", retired_o, 32'd0);
    check("rst_r4", rs_data_o, 32'd0);
    check("rst_r5", rt_data_o, 32'd0);
    type_i = 3'b000; ir_i = 32'd4 << 11; aluout_i = 32'h9;
    step(); nop();
    #1;
    check("post_rst_r4", rs_data_o, 32'h9);
    check("post_rst_retired", retired_o, 32'd1);

    // Eight more retirements: wide counter reaches 9, 3-bit counter holds at 7
    type_i = 3'b011;
    for (int k = 0; k < 8; k++) step();
    nop();
    #1;
    check("cnt_wide", retired_o, 32'd9);
    check("cnt_sat", {29'd0, s_ret}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS32 pipeline, directly downstream of the memory stage. Consumes the memory stage's registered type, instruction, ALU result and load data. Owns the 32×32 general-purpose register file: commits results to it and provides the two combinational read ports used by instruction decode. Also generates the pipeline-wide HALTED flag and a retired-instruction counter.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- TYPE  in  3  instruction class from MEM: 000 RR, 001 RM, 010 LOAD, 011 STORE, 100 BRANCH, 101 HALT, 110/111 NOP
- IR  in  32  instruction word from MEM
- ALUOUT  in  32  ALU result from MEM; meaningful for RR/RM only
- LMD  in  32  load data from MEM; meaningful for LOAD only
- TAKEN_BRANCH  in  1  squash: the instruction at the stage input is discarded
- RS_ADDR, RT_ADDR  in  5 each  decode-stage read addresses
- RS_DATA, RT_DATA  out  32 each  combinational read data
- WB_EN  out  1  a register write commits at the next posedge (combinational)
- WB_ADDR  out  5  destination of that write
- WB_DATA  out  32  value of that write
- HALTED  out  1  sticky halt flag, registered
- RETIRED  out  CNT_W  count of retired instructions, registered

## Operation
- Destination select:
  - RR uses rd = IR[15:11].
  - RM and LOAD use rt = IR[20:16].
- Write value:
  - RR/RM write ALUOUT.
  - LOAD writes LMD.
- An instruction is live when HALTED=0, TAKEN_BRANCH=0 and TYPE ≤ 101.
- WB_EN = live AND TYPE ∈ {000,001,010} AND destination ≠ 0.
  - Register 0 is never written.
  - WB_ADDR/WB_DATA are the destination and value above.
  - Both are 0 when WB_EN=0.
- On posedge with WB_EN=1, the register at WB_ADDR takes WB_DATA.
- STORE and BRANCH never write. A live STORE, BRANCH or HALT still retires.
- HALT: a live TYPE=101 sets HALTED at the posedge. HALTED stays 1 until rst.
  - While HALTED=1: no writes, RETIRED frozen, inputs ignored.
- RETIRED increments by 1 per live instruction, including the HALT itself. It saturates at all-ones, with no wrap.
- Reads:
  - RS_DATA = regfile[RS_ADDR] and RT_DATA = regfile[RT_ADDR], combinational.
  - Address 0 always reads 0.
  - Same-cycle write/read collision behaviour is set under Configuration.
- Reset (rst=1 at posedge):
  - All 32 registers become 0. HALTED=0, RETIRED=0.
  - Any write presented in that cycle is dropped.
  - Reset mid-halt clears the halt, and the stage resumes on the next cycle.
- Simultaneous events:
  - TAKEN_BRANCH=1 with TYPE=101 means the halt is squashed and HALTED stays 0.
  - TAKEN_BRANCH=1 with a LOAD means no write and no count.

## Timing
- Inputs are registered MEM outputs. Write-back completes within 1 cycle of the MEM result appearing.
- Register value is visible to a non-bypassed read in the cycle after the commit edge.
- WB_EN/WB_ADDR/WB_DATA are valid in the same cycle as the inputs. They are combinational, for forwarding into EX.
- HALTED and RETIRED update exactly at the commit posedge. Latency is 1 cycle from the HALT at the input to HALTED=1.
- Read ports have zero-cycle latency and no registered stage.
- Reset values: RS_DATA/RT_DATA reflect the zeroed file (0). WB_EN=0 only if inputs are benign. HALTED=0, RETIRED=0.

## Configuration
- WB_BYPASS_EN defined:
  - When WB_EN=1 and a read address equals WB_ADDR (≠0), that read port returns WB_DATA in the same cycle (write-through).
- WB_BYPASS_EN undefined:
  - Read ports return the pre-write register contents.
  - Decode must see the new value one cycle later; the hazard unit inserts one extra bubble.
- No other behaviour changes.

## Test plan
- Reset, then read all 32 addresses → 0. HALTED=0, RETIRED=0.
- RR, IR rd=5, ALUOUT=0x1234_5678 → R5=0x12345678 after the edge. RETIRED=1. WB_EN=1, WB_ADDR=5 in the presenting cycle.
- LOAD, IR rt=0, LMD=0xDEADBEEF → WB_EN=0 and R0 still reads 0. RETIRED increments.
- RM to rt=7, ALUOUT=0xA5, with TAKEN_BRANCH=1 → R7 unchanged and RETIRED unchanged. Next cycle TYPE=101 with TAKEN_BRANCH=0 → HALTED=1. A following RR to R9 is ignored and RETIRED is frozen.
- Same-cycle RR write R3=0x55 and RS_ADDR=3 (R3 previously 0x11) → RS_DATA=0x55 with WB_BYPASS_EN, 0x11 without. Both read 0x55 next cycle.
- Assert rst while HALTED=1, with an RR to R4 presented → HALTED=0, R4=0, RETIRED=0. Next RR to R4=0x9 commits normally.
